// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   state_t            : converter FSM states
//   BCD_DIGIT_W        : bits per BCD digit
//   BCD_MAX_DIGIT      : largest legal BCD digit value
//   BCD_ADJ            : correction subtracted from a digit after each right shift
//   bcd_digit_invalid  : 1 when a 4-bit digit is outside 0..9
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int BCD_ADJ       = 3;

  function automatic logic bcd_digit_invalid(input logic [3:0] digit);
    return digit > 4'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle for bcd_to_binary_seq.
//   in_valid / in_ready / bcd_input           : BCD word into the converter
//   out_valid / out_ready / binary_output /
//   bcd_error                                 : result out of the converter
// The converter uses the slave modport; the source/sink side uses master.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_input;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      binary_output;
  logic                  bcd_error;

  modport master (
    output in_valid,
    output bcd_input,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  binary_output,
    input  bcd_error
  );

  modport slave (
    input  in_valid,
    input  bcd_input,
    input  out_ready,
    output in_ready,
    output out_valid,
    output binary_output,
    output bcd_error
  );

endinterface

// File: rtl/bcd_to_binary_seq_digit_adjust.sv
// One BCD digit correction cell for reverse double-dabble.
//   din  : digit after the right shift
//   dout : din - 3 when din >= 8, otherwise din unchanged
// A digit >= 8 after a shift means it received a carried-in half-ten (worth 5
// in decimal but 8 in binary), so 3 is removed to restore BCD weighting.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? (din - 4'(BCD_ADJ)) : din;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, aborts any conversion in flight
//   bus  : slave side of bcd_to_binary_seq_if
//          in_valid/in_ready/bcd_input accept a packed BCD word (digit 0 = ones)
//          out_valid/out_ready/binary_output/bcd_error return the result
// A valid word takes BIN_W shift/adjust iterations; a word containing a digit
// above 9 skips conversion and reports bcd_error with a zero result.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic               clk,
  input  logic               rst,
  bcd_to_binary_seq_if.slave bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t             state_reg;
  logic [SR_W-1:0]    sr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [BIN_W-1:0]   bin_out_reg;
  logic               err_reg;

  logic [SR_W-1:0]    sr_shift;
  logic [BCD_W-1:0]   bcd_adj;
  logic [SR_W-1:0]    sr_next;
  logic               input_invalid;

  // Shift the {bcd, bin} pair right; bcd LSB falls into bin MSB.
  assign sr_shift = sr_reg >> 1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .din  (sr_shift[BIN_W + BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
        .dout (bcd_adj[BCD_DIGIT_W*gi +: BCD_DIGIT_W])
      );
    end
  endgenerate

  assign sr_next = {bcd_adj, sr_shift[BIN_W-1:0]};

  always_comb begin
    input_invalid = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_digit_invalid(bus.bcd_input[BCD_DIGIT_W*k +: BCD_DIGIT_W])) begin
        input_invalid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      bin_out_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            in_ready_reg <= 1'b0;
            if (input_invalid) begin
              // out_valid is raised by DONE one edge later.
              state_reg   <= DONE;
              err_reg     <= 1'b1;
              bin_out_reg <= '0;
            end else begin
              state_reg <= CONV;
              sr_reg    <= {bus.bcd_input, BIN_W'(0)};
              cnt_reg   <= '0;
            end
          end
        end

        CONV: begin
          sr_reg  <= sr_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_ITER) begin
            // Present the result on the same edge as the final iteration.
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            bin_out_reg   <= sr_next[BIN_W-1:0];
            err_reg       <= 1'b0;
          end
        end

        DONE: begin
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Every legal input drains the BCD field to zero after BIN_W iterations.
  always_ff @(posedge clk) begin
    if (!rst && state_reg == CONV && cnt_reg == LAST_ITER) begin
      assert (sr_next[SR_W-1:BIN_W] == '0);
    end
  end

  assign bus.in_ready      = in_ready_reg;
  assign bus.out_valid     = out_valid_reg;
  assign bus.binary_output = bin_out_reg;
  assign bus.bcd_error     = err_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases, back-pressure,
// mid-conversion reset, a 0..99 round-trip sweep and random traffic, all
// checked against a decimal-arithmetic scoreboard every cycle.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  always @(posedge clk) cyc++;

  typedef struct {
    int value;
    bit err;
    int acc_cyc;
    bit seen;
  } exp_t;

  exp_t q[$];

  // Reference: plain decimal weighting of the digits, error if any digit > 9.
  function automatic void ref_model(input logic [4*DIGITS-1:0] b, output int value, output bit err);
    int d;
    value = 0;
    err   = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      d = int'(b[4*k +: 4]);
      if (d > 9) err = 1'b1;
      value = value * 10 + d;
    end
    if (err) value = 0;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] b;
    int r;
    b = '0;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      b[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard: checks state seen after the previous edge, then records what
  // the coming edge will do (accept / hand off / reset).
  always @(negedge clk) begin
    int v;
    bit e;
    if (armed) begin
      chk("in_ready", int'(bus.in_ready), int'(q.size() == 0));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          fail("spurious out_valid");
        end else begin
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            chk("latency", cyc - q[0].acc_cyc - 1, q[0].err ? 1 : BIN_W);
          end
          chk("sb binary_output", int'(bus.binary_output), q[0].value);
          chk("sb bcd_error", int'(bus.bcd_error), int'(q[0].err));
        end
      end else if (q.size() > 0 && q[0].seen) begin
        fail("out_valid dropped before handshake");
      end
    end
    if (rst) begin
      q.delete();
      armed = 1'b1;
    end else if (armed) begin
      if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        ref_model(bus.bcd_input, v, e);
        q.push_back('{value: v, err: e, acc_cyc: cyc, seen: 1'b0});
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [4*DIGITS-1:0] b);
    int t;
    t = 0;
    bus.bcd_input = b;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready) begin
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        fail("send timeout");
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input bit rdy_random, output int val, output bit err);
    int t;
    t = 0;
    val = -1;
    err = 1'b0;
    forever begin
      bus.out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        val = int'(bus.binary_output);
        err = bus.bcd_error;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        fail("collect timeout");
        bus.out_ready = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_one(input logic [4*DIGITS-1:0] b, input int exp_val, input bit exp_err,
                         input bit rdy_random);
    int v;
    bit e;
    send(b);
    collect(rdy_random, v, e);
    $display("txn bcd=%h -> binary_output=%0d bcd_error=%0d", b, v, e);
    chk($sformatf("result %h", b), v, exp_val);
    chk($sformatf("error %h", b), int'(e), int'(exp_err));
  endtask

  // Directed case with a hand-computed literal that also pins the model.
  task automatic directed(input logic [4*DIGITS-1:0] b, input int lit_val, input bit lit_err);
    int mv;
    bit me;
    ref_model(b, mv, me);
    chk($sformatf("model %h", b), mv, lit_val);
    chk($sformatf("model err %h", b), int'(me), int'(lit_err));
    run_one(b, lit_val, lit_err, 1'b0);
  endtask

  initial begin
    int held;
    int ov_cnt;
    int v;
    bit e;
    logic [4*DIGITS-1:0] b;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.bcd_input = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset binary_output", int'(bus.binary_output), 0);
    chk("reset bcd_error", int'(bus.bcd_error), 0);

    directed(8'h00, 0, 1'b0);
    directed(8'h99, 99, 1'b0);
    directed(8'h31, 31, 1'b0);
    directed(8'h10, 10, 1'b0);
    directed(8'h1A, 0, 1'b1);
    directed(8'hF0, 0, 1'b1);
    directed(8'h09, 9, 1'b0);

    // Back-pressure: result held while a new word is offered and refused.
    send(8'h27);
    held = 0;
    while (!bus.out_valid && held < 20) begin
      @(posedge clk); #1;
      held++;
    end
    chk("bp out_valid", int'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'b1;
      bus.bcd_input = 8'h42;
      @(posedge clk); #1;
      chk("bp in_ready", int'(bus.in_ready), 0);
      chk("bp held value", int'(bus.binary_output), 27);
      chk("bp held valid", int'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    collect(1'b0, v, e);
    chk("bp release value", v, 27);
    run_one(8'h42, 42, 1'b0, 1'b0);

    // Reset during the third iteration: nothing may come out afterwards.
    send(8'h77);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid", int'(bus.out_valid), 0);
    chk("abort in_ready", int'(bus.in_ready), 1);
    ov_cnt = 0;
    bus.out_ready = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_cnt++;
    end
    bus.out_ready = 1'b0;
    chk("abort no result", ov_cnt, 0);

    // Round trip 0..99 (binary -> BCD -> converter), random out_ready.
    for (int n = 0; n < 100; n++) begin
      run_one(to_bcd(n), n, 1'b0, 1'b1);
    end

    // Random words, about one in eight digits illegal, random gaps.
    for (int n = 0; n < 120; n++) begin
      for (int k = 0; k < DIGITS; k++) begin
        if ($urandom_range(0, 7) == 0) b[4*k +: 4] = 4'($urandom_range(10, 15));
        else                          b[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      ref_model(b, v, e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_one(b, v, e, 1'b1);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential BCD-to-binary converter. It is the inverse of the team's combinational binary-to-BCD converter. It accepts a packed multi-digit BCD word through a valid/ready handshake and converts it iteratively using reverse double-dabble (shift right, then subtract 3 from every digit that is >= 8). It returns the binary value through a second valid/ready handshake. It sits downstream of BCD sources such as keypad or display-register readback, and feeds binary datapaths.

Parameters:
DIGITS, 2, number of BCD digits in the input; legal range 1..8.
BIN_W, 7, binary output width; must satisfy 2^BIN_W > 10^DIGITS - 1 (DIGITS=2 -> BIN_W=7).

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  reset; synchronous and active-high
in_valid  input  1  bcd_input is valid
in_ready  output  1  block can accept; high only in IDLE
bcd_input  input  4*DIGITS  packed BCD; digit k is bits [4k+3:4k], digit 0 is the ones digit
out_valid  output  1  binary_output and bcd_error are valid
out_ready  input  1  consumer accepts the result
binary_output  output  BIN_W  converted value
bcd_error  output  1  input contained a digit > 9

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE; in_ready=1; out_valid=0; binary_output=0; bcd_error=0; internal shift register and counter cleared.
- Reset mid-operation: aborts any conversion or pending result immediately. No result is emitted for the aborted transaction.
- States: IDLE, CONV, DONE.
- IDLE, on in_valid & in_ready at an edge:
  - If any digit of bcd_input is > 9: go to DONE with bcd_error=1 and binary_output=0. out_valid is high in the next cycle.
  - Otherwise: load shift register {bcd=bcd_input, bin=0}, set cnt=0, go to CONV.
- CONV, each cycle:
  - Shift {bcd, bin} right by 1; the bcd LSB enters the bin MSB.
  - For each digit in the post-shift bcd field: if the digit is >= 8, subtract 3 (4-bit, no borrow across digits).
  - cnt increments; after BIN_W iterations go to DONE with bcd_error=0.
- DONE: out_valid=1. binary_output and bcd_error are held stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE, out_valid=0.
  - binary_output keeps its last value; it is don't-care when out_valid=0.
- Latency: for valid input, out_valid rises exactly BIN_W edges after the accepting edge (7 for the defaults). For invalid input, it rises 1 edge after.
- Throughput: one conversion per BIN_W+2 cycles minimum. No overlap: in_ready=0 in CONV and DONE.
- in_valid while busy: ignored; bcd_input is not sampled.
- Width rules:
  - cnt width is $clog2(BIN_W+1).
  - The bcd field is 0 after BIN_W iterations for every valid input. A non-zero residue is a design error and is flagged by an assertion, not reported on a port.
- Boundaries:
  - All-zeros input yields 0.
  - All-nines yields 10^DIGITS - 1 (99 for defaults).
  - A digit of exactly 9 must not trigger a false bcd_error.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, CONV, DONE}
  - localparam BCD_DIGIT_W=4
  - localparam BCD_MAX_DIGIT=9
  - localparam BCD_ADJ=3
  - function bcd_digit_invalid(4-bit)
- Sub-module bcd_digit_adjust: a 4-bit combinational cell (out = in >= 8 ? in - 3 : in), instantiated DIGITS times via generate.

Test Plan:
1. Reset, then bcd_input=8'h00 with in_valid pulse -> after 7 edges out_valid=1, binary_output=0, bcd_error=0.
2. bcd_input=8'h99 -> binary_output=7'd99 (7'b1100011) exactly 7 edges after acceptance. Also 8'h31 -> 31, and 8'h10 -> 10.
3. bcd_input=8'h1A, then 8'hF0 -> out_valid one edge after acceptance, bcd_error=1, binary_output=0. Input 8'h09 -> bcd_error=0, result 9.
4. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> output stable, in_ready=0. Drive in_valid with 8'h42 during that window -> not accepted. Release -> IDLE, then 8'h42 accepted -> 42.
5. Assert rst for 1 cycle during CONV (iteration 3) -> next cycle state IDLE, out_valid=0, in_ready=1. The aborted conversion produces no result.
6. Round trip: sweep 0..31 through binary_to_bcd_converter into this block, with random out_ready -> binary_output equals the original value for every case. Also sweep 0..99 directly against a reference model.
